// File: rtl/cpu_pkg.sv
`default_nettype none
// cpu_pkg: opcode/condition encodings, controller state codes and decode helpers
// shared by the CR16-style multicycle control unit.
package cpu_pkg;

  localparam logic [3:0] OP_RTYPE  = 4'b0000;
  localparam logic [3:0] OP_MEM    = 4'b0100;
  localparam logic [3:0] OP_BCOND  = 4'b1100;
  localparam logic [3:0] OP_CMPI   = 4'b1011;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_CMP   = 4'b1011;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_HI = 4'b0100;
  localparam logic [3:0] CC_LS = 4'b0101;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;
  localparam logic [3:0] CC_FS = 4'b1000;
  localparam logic [3:0] CC_FC = 4'b1001;
  localparam logic [3:0] CC_LO = 4'b1010;
  localparam logic [3:0] CC_HS = 4'b1011;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GE = 4'b1101;
  localparam logic [3:0] CC_UC = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  localparam logic [1:0] PC_SEL_INC  = 2'b00;
  localparam logic [1:0] PC_SEL_REG  = 2'b01;
  localparam logic [1:0] PC_SEL_DISP = 2'b10;

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM_RD = 3'd4;
  localparam logic [2:0] ST_MEM_WR = 3'd5;
  localparam logic [2:0] ST_WB     = 3'd6;
  localparam logic [2:0] ST_FAULT  = 3'd7;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_CMP,
    CLS_LOAD,
    CLS_STOR,
    CLS_JCOND,
    CLS_JAL,
    CLS_BCOND,
    CLS_ILLEGAL
  } instr_cls_e;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

  function automatic logic is_imm_op(input logic [3:0] op);
    return !(op == OP_RTYPE || op == OP_MEM || op == OP_BCOND);
  endfunction

  // Only the memory/jump group has reserved ext codes; every other op is an ALU form.
  function automatic instr_cls_e decode_cls(input logic [3:0] op, input logic [3:0] ext);
    if (op == OP_MEM) begin
      case (ext)
        EXT_LOAD:  return CLS_LOAD;
        EXT_STOR:  return CLS_STOR;
        EXT_JCOND: return CLS_JCOND;
        EXT_JAL:   return CLS_JAL;
        default:   return CLS_ILLEGAL;
      endcase
    end else if (op == OP_BCOND) begin
      return CLS_BCOND;
    end else if ((op == OP_RTYPE && ext == EXT_CMP) || op == OP_CMPI) begin
      return CLS_CMP;
    end
    return CLS_ALU;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl_fsm_cond_eval.sv
`default_nettype none
// cond_eval: combinational branch-condition evaluation from the PSR flags.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  logic c, l, f, z, n;

  assign c = flags[FLAG_C];
  assign l = flags[FLAG_L];
  assign f = flags[FLAG_F];
  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];

  always_comb begin
    case (cond)
      CC_EQ:   taken = z;
      CC_NE:   taken = !z;
      CC_CS:   taken = c;
      CC_CC:   taken = !c;
      CC_HI:   taken = l;
      CC_LS:   taken = !l;
      CC_GT:   taken = n;
      CC_LE:   taken = !n;
      CC_FS:   taken = f;
      CC_FC:   taken = !f;
      CC_LO:   taken = !l && !z;
      CC_HS:   taken = l || z;
      CC_LT:   taken = !n && !z;
      CC_GE:   taken = n || z;
      CC_UC:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl_fsm.sv
`default_nettype none
// cpu_ctrl_fsm: multicycle control unit with memory wait states, branch evaluation
// and a bus-fault timeout. Every output is registered and reflects the current state.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int NUM_REGS     = 16,
  parameter int WAIT_TIMEOUT = 15,
  localparam int REG_SEL_W   = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    instr_in,
  input  logic                 mem_ready,
  input  logic [4:0]           flags,
  output logic [DATA_W-1:0]    ir,
  output logic [REG_SEL_W-1:0] src_a_sel,
  output logic [REG_SEL_W-1:0] src_b_sel,
  output logic [NUM_REGS-1:0]  reg_en,
  output logic                 imm_sel,
  output logic                 wb_sel,
  output logic                 flag_en,
  output logic                 pc_en,
  output logic [1:0]           pc_sel,
  output logic                 addr_sel,
  output logic                 mem_w_en,
  output logic                 link_en,
  output logic                 bus_fault,
  output logic                 illegal
);

  localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

  logic [2:0]          r_state;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic                r_taken;
  logic                w_cond_true;
  logic                w_rd_bad;
  logic                w_timeout;
  logic [15:0]         w_oh16;
  logic [NUM_REGS-1:0] w_rd_oh;
  instr_cls_e          w_cls;

  cond_eval u_cond_eval (
    .cond  (ir[11:8]),
    .flags (flags),
    .taken (w_cond_true)
  );

  assign w_oh16  = onehot16(ir[11:8]);
  assign w_rd_oh = w_oh16[NUM_REGS-1:0];

  generate
    if (NUM_REGS < 16) begin : g_rd_range
      assign w_rd_bad = (ir[11:8] >= 4'(NUM_REGS));
    end else begin : g_rd_full
      assign w_rd_bad = 1'b0;
    end
  endgenerate

  // A register-writing instruction aimed past the register file decays to an illegal NOP.
  always_comb begin
    w_cls = decode_cls(ir[15:12], ir[7:4]);
    if (w_rd_bad && (w_cls inside {CLS_ALU, CLS_LOAD, CLS_JAL})) begin
      w_cls = CLS_ILLEGAL;
    end
  end

  assign w_timeout = (WAIT_TIMEOUT != 0) && (r_wait_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RESET;
      r_wait_cnt <= '0;
      r_taken    <= 1'b0;
      ir         <= '0;
      src_a_sel  <= '0;
      src_b_sel  <= '0;
      reg_en     <= '0;
      imm_sel    <= 1'b0;
      wb_sel     <= 1'b1;
      flag_en    <= 1'b0;
      pc_en      <= 1'b0;
      pc_sel     <= PC_SEL_INC;
      addr_sel   <= 1'b0;
      mem_w_en   <= 1'b0;
      link_en    <= 1'b0;
      bus_fault  <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      // Outputs are set on entry to the state they belong to; strobes idle otherwise.
      reg_en     <= '0;
      flag_en    <= 1'b0;
      pc_en      <= 1'b0;
      pc_sel     <= PC_SEL_INC;
      addr_sel   <= 1'b0;
      mem_w_en   <= 1'b0;
      link_en    <= 1'b0;
      wb_sel     <= 1'b1;
      illegal    <= 1'b0;
      r_wait_cnt <= '0;

      case (r_state)
        ST_RESET: r_state <= ST_FETCH;

        ST_FETCH: begin
          if (mem_ready) begin
            ir        <= instr_in;
            src_a_sel <= instr_in[8 +: REG_SEL_W];
            src_b_sel <= instr_in[0 +: REG_SEL_W];
            imm_sel   <= is_imm_op(instr_in[15:12]);
            r_state   <= ST_DECODE;
          end else if (w_timeout) begin
            bus_fault <= 1'b1;
            r_state   <= ST_FAULT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        ST_DECODE: begin
          r_taken <= w_cond_true;
          r_state <= ST_EXEC;
          case (w_cls)
            CLS_ALU: begin
              reg_en  <= w_rd_oh;
              flag_en <= 1'b1;
            end
            CLS_CMP: flag_en <= 1'b1;
            CLS_LOAD: addr_sel <= 1'b1;
            CLS_STOR: begin
              addr_sel <= 1'b1;
              mem_w_en <= 1'b1;
            end
            CLS_JAL: begin
              link_en <= 1'b1;
              reg_en  <= w_rd_oh;
              pc_sel  <= PC_SEL_REG;
              pc_en   <= 1'b1;
            end
            CLS_JCOND: if (w_cond_true) begin
              pc_sel <= PC_SEL_REG;
              pc_en  <= 1'b1;
            end
            CLS_BCOND: if (w_cond_true) begin
              pc_sel <= PC_SEL_DISP;
              pc_en  <= 1'b1;
            end
            default: begin
              illegal <= 1'b1;
              pc_en   <= 1'b1;
              r_state <= ST_WB;
            end
          endcase
        end

        ST_EXEC: begin
          case (w_cls)
            CLS_LOAD: begin
              addr_sel <= 1'b1;
              r_state  <= ST_MEM_RD;
            end
            CLS_STOR: begin
              addr_sel <= 1'b1;
              mem_w_en <= 1'b1;
              r_state  <= ST_MEM_WR;
            end
            CLS_JAL: r_state <= ST_FETCH;
            CLS_JCOND, CLS_BCOND: begin
              if (r_taken) begin
                r_state <= ST_FETCH;
              end else begin
                pc_en   <= 1'b1;
                r_state <= ST_WB;
              end
            end
            default: begin
              pc_en   <= 1'b1;
              r_state <= ST_WB;
            end
          endcase
        end

        ST_MEM_RD: begin
          if (mem_ready) begin
            wb_sel  <= 1'b0;
            reg_en  <= w_rd_oh;
            pc_en   <= 1'b1;
            r_state <= ST_WB;
          end else if (w_timeout) begin
            bus_fault <= 1'b1;
            r_state   <= ST_FAULT;
          end else begin
            addr_sel   <= 1'b1;
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        ST_MEM_WR: begin
          if (mem_ready) begin
            pc_en   <= 1'b1;
            r_state <= ST_WB;
          end else if (w_timeout) begin
            bus_fault <= 1'b1;
            r_state   <= ST_FAULT;
          end else begin
            addr_sel   <= 1'b1;
            mem_w_en   <= 1'b1;
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        ST_WB: r_state <= ST_FETCH;

        ST_FAULT: r_state <= ST_FAULT;

        default: r_state <= ST_RESET;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
`default_nettype none
// tb_cpu_ctrl_fsm: directed self-checking bench for cpu_ctrl_fsm at default parameters.
module tb_cpu_ctrl_fsm;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] instr_in;
  logic        mem_ready;
  logic [4:0]  flags;
  logic [15:0] ir;
  logic [3:0]  src_a_sel;
  logic [3:0]  src_b_sel;
  logic [15:0] reg_en;
  logic        imm_sel;
  logic        wb_sel;
  logic        flag_en;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic        addr_sel;
  logic        mem_w_en;
  logic        link_en;
  logic        bus_fault;
  logic        illegal;
  logic [8:0]  ctl;

  int n_checks = 0;
  int n_errors = 0;

  // {flag_en, pc_en, pc_sel[1:0], addr_sel, mem_w_en, link_en, wb_sel, illegal}
  localparam logic [8:0] CTL_IDLE = 9'b0_0_00_0_0_0_1_0;

  assign ctl = {flag_en, pc_en, pc_sel, addr_sel, mem_w_en, link_en, wb_sel, illegal};

  cpu_ctrl_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .instr_in  (instr_in),
    .mem_ready (mem_ready),
    .flags     (flags),
    .ir        (ir),
    .src_a_sel (src_a_sel),
    .src_b_sel (src_b_sel),
    .reg_en    (reg_en),
    .imm_sel   (imm_sel),
    .wb_sel    (wb_sel),
    .flag_en   (flag_en),
    .pc_en     (pc_en),
    .pc_sel    (pc_sel),
    .addr_sel  (addr_sel),
    .mem_w_en  (mem_w_en),
    .link_en   (link_en),
    .bus_fault (bus_fault),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    instr_in  = 16'h0000;
    mem_ready = 1'b0;
    flags     = 5'b00000;
    tick();
    tick();
    check_eq("rst_state", 32'(dut.r_state), 32'(ST_RESET));
    check_eq("rst_ctl", 32'(ctl), 32'(CTL_IDLE));
    check_eq("rst_reg_en", 32'(reg_en), 32'h0);
    check_eq("rst_ir", 32'(ir), 32'h0);
    check_eq("rst_bus_fault", 32'(bus_fault), 32'h0);

    reset = 1'b0;
    tick();
    check_eq("fetch_after_rst", 32'(dut.r_state), 32'(ST_FETCH));

    // ADD R3,R5
    instr_in = 16'h0355; mem_ready = 1'b1;
    tick();
    check_eq("add_src_a", 32'(src_a_sel), 32'd3);
    check_eq("add_src_b", 32'(src_b_sel), 32'd5);
    check_eq("add_dec_ctl", 32'(ctl), 32'(CTL_IDLE));
    tick();
    check_eq("add_exec_reg_en", 32'(reg_en), 32'h0008);
    check_eq("add_exec_ctl", 32'(ctl), 32'(9'b1_0_00_0_0_0_1_0));
    tick();
    check_eq("add_wb_reg_en", 32'(reg_en), 32'h0);
    check_eq("add_wb_ctl", 32'(ctl), 32'(9'b0_1_00_0_0_0_1_0));
    tick();
    check_eq("add_4cyc_fetch", 32'(dut.r_state), 32'(ST_FETCH));

    // CMPI: immediate operand, flags only
    instr_in = 16'hB3FF;
    tick();
    check_eq("cmpi_imm_sel", 32'(imm_sel), 32'h1);
    tick();
    check_eq("cmpi_reg_en", 32'(reg_en), 32'h0);
    check_eq("cmpi_ctl", 32'(ctl), 32'(9'b1_0_00_0_0_0_1_0));
    tick();
    tick();

    // LOAD R2,[R7] with three wait cycles
    instr_in = 16'h4207;
    tick();
    check_eq("ld_src_b", 32'(src_b_sel), 32'd7);
    mem_ready = 1'b0;
    tick();
    check_eq("ld_exec_ctl", 32'(ctl), 32'(9'b0_0_00_1_0_0_1_0));
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("ld_wait_addr_sel", 32'({dut.r_state, addr_sel, 16'(reg_en)}), 32'({ST_MEM_RD, 1'b1, 16'h0}));
    end
    mem_ready = 1'b1;
    tick();
    check_eq("ld_wb_reg_en", 32'(reg_en), 32'h0004);
    check_eq("ld_wb_ctl", 32'(ctl), 32'(9'b0_1_00_0_0_0_0_0));
    tick();
    check_eq("ld_8cyc_fetch", 32'(dut.r_state), 32'(ST_FETCH));

    // Reset while a LOAD is waiting in MEM_RD
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    check_eq("ld2_in_mem_rd", 32'(dut.r_state), 32'(ST_MEM_RD));
    reset = 1'b1;
    tick();
    check_eq("mid_rst_state", 32'(dut.r_state), 32'(ST_RESET));
    check_eq("mid_rst_ctl", 32'(ctl), 32'(CTL_IDLE));
    check_eq("mid_rst_bus_fault", 32'(bus_fault), 32'h0);
    reset = 1'b0;
    mem_ready = 1'b1;
    tick();

    // Bcond EQ taken
    instr_in = 16'hC004; flags = 5'b00010;
    tick();
    tick();
    check_eq("beq_taken_ctl", 32'(ctl), 32'(9'b0_1_10_0_0_0_1_0));
    tick();
    check_eq("beq_taken_3cyc", 32'(dut.r_state), 32'(ST_FETCH));

    // Bcond EQ not taken
    flags = 5'b00000;
    tick();
    tick();
    check_eq("beq_nt_exec_ctl", 32'(ctl), 32'(CTL_IDLE));
    tick();
    check_eq("beq_nt_wb_ctl", 32'(ctl), 32'(9'b0_1_00_0_0_0_1_0));
    tick();

    // Undefined opcode then JAL R14,R2
    instr_in = 16'h4F30;
    tick();
    tick();
    check_eq("undef_wb_ctl", 32'(ctl), 32'(9'b0_1_00_0_0_0_1_1));
    tick();
    check_eq("undef_pulse_once", 32'(illegal), 32'h0);
    instr_in = 16'h4E82;
    tick();
    tick();
    check_eq("jal_reg_en", 32'(reg_en), 32'h4000);
    check_eq("jal_ctl", 32'(ctl), 32'(9'b0_1_01_0_0_1_1_0));
    tick();
    check_eq("jal_3cyc_fetch", 32'(dut.r_state), 32'(ST_FETCH));

    // STOR with the memory never ready: bus fault after 15 wait cycles
    instr_in = 16'h4142;
    tick();
    mem_ready = 1'b0;
    tick();
    check_eq("st_exec_ctl", 32'(ctl), 32'(9'b0_0_00_1_1_0_1_0));
    tick();
    for (int i = 0; i < 14; i++) begin
      check_eq("st_wait_no_fault", 32'({bus_fault, mem_w_en}), 32'(2'b01));
      tick();
    end
    check_eq("st_last_wait", 32'({bus_fault, mem_w_en}), 32'(2'b01));
    tick();
    check_eq("st_bus_fault", 32'(bus_fault), 32'h1);
    check_eq("st_fault_state", 32'(dut.r_state), 32'(ST_FAULT));
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("fault_quiet", 32'({bus_fault, ctl, reg_en}), 32'({1'b1, CTL_IDLE, 16'h0}));
    end
    reset = 1'b1;
    tick();
    check_eq("fault_cleared", 32'(bus_fault), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
